// File: rtl/instruction_block_fill_unit.sv
// Instruction-cache block fill engine: takes a block address, streams 16 word reads
// to memory, assembles the in-order returns into one 512-bit block and hands it back.
module instruction_block_fill_unit #(
    parameter int unsigned ADDRESS_WIDTH       = 32,
    parameter int unsigned WORD_SIZE           = 4,
    parameter int unsigned WORD_PER_BLOCK      = 16,
    parameter int unsigned L2_BUS_WIDTH        = 32,
    parameter int unsigned BLOCK_ADDRESS_WIDTH = 26
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic                                     ADDRESS_IN_VALID,
    output logic                                     ADDRESS_IN_READY,
    input  logic [BLOCK_ADDRESS_WIDTH-1:0]           ADDRESS_IN,
    output logic                                     MEM_READ_VALID,
    input  logic                                     MEM_READ_READY,
    output logic [ADDRESS_WIDTH-1:0]                 MEM_READ_ADDRESS,
    input  logic                                     MEM_DATA_VALID,
    input  logic [L2_BUS_WIDTH-1:0]                  MEM_DATA,
    output logic                                     DATA_OUT_VALID,
    input  logic                                     DATA_OUT_READY,
    output logic [WORD_PER_BLOCK*L2_BUS_WIDTH-1:0]   DATA_OUT
);

    localparam int unsigned WORD_IDX_W = $clog2(WORD_PER_BLOCK);
    localparam int unsigned BYTE_OFF_W = $clog2(WORD_SIZE);
    localparam int unsigned CNT_W      = WORD_IDX_W + 1;
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(WORD_PER_BLOCK);
    localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(WORD_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                                        state_q, state_d;
    logic [BLOCK_ADDRESS_WIDTH-1:0]                block_addr_q, block_addr_d;
    logic [CNT_W-1:0]                              issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]                              recv_cnt_q, recv_cnt_d;
    // Packed by slot: slot WORD_PER_BLOCK-1 is the MSB word, which holds word 0.
    logic [WORD_PER_BLOCK-1:0][L2_BUS_WIDTH-1:0]   data_q, data_d;
    logic [WORD_IDX_W-1:0]                         slot_idx;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            block_addr_q <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            block_addr_q <= block_addr_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            data_q       <= data_d;
        end
    end

    // Next-state, read issue and in-order data capture
    always_comb begin
        state_d      = state_q;
        block_addr_d = block_addr_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        data_d       = data_q;
        slot_idx     = LAST_IDX - recv_cnt_q[WORD_IDX_W-1:0];

        unique case (state_q)
            IDLE: begin
                if (ADDRESS_IN_VALID) begin
                    block_addr_d = ADDRESS_IN;
                    issue_cnt_d  = '0;
                    recv_cnt_d   = '0;
                    state_d      = FILL;
                end
            end
            FILL: begin
                if ((issue_cnt_q < CNT_MAX) && MEM_READ_READY) begin
                    issue_cnt_d = issue_cnt_q + CNT_W'(1);
                end
                if (MEM_DATA_VALID && (recv_cnt_q < CNT_MAX)) begin
                    data_d[slot_idx] = MEM_DATA;
                    recv_cnt_d       = recv_cnt_q + CNT_W'(1);
                    if (recv_cnt_q == CNT_MAX - CNT_W'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (DATA_OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode directly from flops only
    assign ADDRESS_IN_READY = (state_q == IDLE);
    assign MEM_READ_VALID   = (state_q == FILL) && (issue_cnt_q < CNT_MAX);
    assign MEM_READ_ADDRESS = ADDRESS_WIDTH'({block_addr_q, issue_cnt_q[WORD_IDX_W-1:0],
                                              {BYTE_OFF_W{1'b0}}});
    assign DATA_OUT_VALID   = (state_q == RESP);
    assign DATA_OUT         = data_q;

endmodule

// File: tb/tb_instruction_block_fill_unit.sv
// Directed + randomized bench for instruction_block_fill_unit with an in-order memory model
// and a reference block built from the address-valued memory image.
module tb_instruction_block_fill_unit;

    logic         clk;
    logic         RST;
    logic         ADDRESS_IN_VALID;
    logic         ADDRESS_IN_READY;
    logic [25:0]  ADDRESS_IN;
    logic         MEM_READ_VALID;
    logic         MEM_READ_READY;
    logic [31:0]  MEM_READ_ADDRESS;
    logic         MEM_DATA_VALID;
    logic [31:0]  MEM_DATA;
    logic         DATA_OUT_VALID;
    logic         DATA_OUT_READY;
    logic [511:0] DATA_OUT;

    instruction_block_fill_unit dut (
        .CLK              (clk),
        .RST              (RST),
        .ADDRESS_IN_VALID (ADDRESS_IN_VALID),
        .ADDRESS_IN_READY (ADDRESS_IN_READY),
        .ADDRESS_IN       (ADDRESS_IN),
        .MEM_READ_VALID   (MEM_READ_VALID),
        .MEM_READ_READY   (MEM_READ_READY),
        .MEM_READ_ADDRESS (MEM_READ_ADDRESS),
        .MEM_DATA_VALID   (MEM_DATA_VALID),
        .MEM_DATA         (MEM_DATA),
        .DATA_OUT_VALID   (DATA_OUT_VALID),
        .DATA_OUT_READY   (DATA_OUT_READY),
        .DATA_OUT         (DATA_OUT)
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    int          mem_lat = 1;
    int          issued = 0;
    int          rx_cnt = 0;
    logic [31:0] key = '0;
    logic [31:0] exp_base = '0;
    bit          flush_req = 1'b0;
    bit          spur_req = 1'b0;
    int          pend_due[$];
    logic [31:0] pend_data[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Memory word at byte address A holds A ^ k; word 0 lands in the MSBs.
    function automatic logic [511:0] model(input logic [25:0] blk, input logic [31:0] k);
        logic [511:0] b;
        logic [31:0]  a;
        b = '0;
        for (int j = 0; j < 16; j++) begin
            a = {blk, 6'b0} + 32'(4 * j);
            b[511 - 32*j -: 32] = a ^ k;
        end
        return b;
    endfunction

    // Memory responder: in-order returns mem_lat cycles after accept, plus address checks.
    initial begin
        MEM_READ_READY = 1'b0;
        MEM_DATA_VALID = 1'b0;
        MEM_DATA       = '0;
        forever begin
            @(negedge clk);
            if (flush_req) begin
                pend_due.delete();
                pend_data.delete();
                flush_req = 1'b0;
            end
            case (ready_mode)
                0:       MEM_READ_READY = 1'b1;
                1:       MEM_READ_READY = 1'((cyc & 1) != 0);
                default: MEM_READ_READY = 1'($urandom_range(0, 1));
            endcase
            MEM_DATA_VALID = 1'b0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                MEM_DATA_VALID = 1'b1;
                MEM_DATA       = pend_data[0];
                void'(pend_due.pop_front());
                void'(pend_data.pop_front());
                rx_cnt++;
            end else if (spur_req) begin
                MEM_DATA_VALID = 1'b1;
                MEM_DATA       = $urandom;
                spur_req       = 1'b0;
            end
            if (MEM_READ_VALID === 1'b1) begin
                check("rd_addr", MEM_READ_ADDRESS, exp_base + 32'(4 * issued));
                check("rd_count", 1'(issued < 16), 1'b1);
                if (MEM_READ_READY) begin
                    pend_due.push_back(cyc + mem_lat);
                    pend_data.push_back(MEM_READ_ADDRESS ^ key);
                    issued++;
                end
            end
        end
    end

    task automatic request(input logic [25:0] blk);
        check("ain_ready_idle", ADDRESS_IN_READY, 1'b1);
        exp_base = {blk, 6'b0};
        issued   = 0;
        rx_cnt   = 0;
        ADDRESS_IN       = blk;
        ADDRESS_IN_VALID = 1'b1;
        @(negedge clk);
        ADDRESS_IN_VALID = 1'b0;
        ADDRESS_IN       = 26'($urandom);
        check("rd_valid_lat1", MEM_READ_VALID, 1'b1);
        check("ain_busy", ADDRESS_IN_READY, 1'b0);
    endtask

    task automatic wait_valid(output int lat);
        int n;
        n = 0;
        while (DATA_OUT_VALID !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("dov_timeout", DATA_OUT_VALID, 1'b1);
        lat = n + 1;
    endtask

    task automatic stall(input int cycles, input logic [511:0] held);
        for (int i = 0; i < cycles; i++) begin
            if (i == 1) begin
                ADDRESS_IN_VALID = 1'b1;
                ADDRESS_IN       = 26'h155;
            end
            @(negedge clk);
            ADDRESS_IN_VALID = 1'b0;
            check("stall_dov", DATA_OUT_VALID, 1'b1);
            check("stall_data", DATA_OUT, held);
            check("stall_ain_ready", ADDRESS_IN_READY, 1'b0);
            check("stall_no_rd", MEM_READ_VALID, 1'b0);
        end
    endtask

    task automatic handshake();
        DATA_OUT_READY = 1'b1;
        @(negedge clk);
        DATA_OUT_READY = 1'b0;
        check("hs_dov_drop", DATA_OUT_VALID, 1'b0);
        check("hs_ain_ready", ADDRESS_IN_READY, 1'b1);
        check("hs_no_rd", MEM_READ_VALID, 1'b0);
    endtask

    task automatic fill(input logic [25:0] blk, input int stall_cycles);
        int lat;
        logic [511:0] held;
        request(blk);
        wait_valid(lat);
        held = DATA_OUT;
        check("block", DATA_OUT, model(blk, key));
        stall(stall_cycles, held);
        handshake();
    endtask

    initial begin
        int lat;
        int n;
        logic [511:0] saved;
        logic [25:0]  blk;

        RST              = 1'b1;
        ADDRESS_IN_VALID = 1'b0;
        ADDRESS_IN       = '0;
        DATA_OUT_READY   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ain_ready", ADDRESS_IN_READY, 1'b1);
        check("rst_rd_valid", MEM_READ_VALID, 1'b0);
        check("rst_dov", DATA_OUT_VALID, 1'b0);
        check("rst_rd_addr", MEM_READ_ADDRESS, 32'h0);
        check("rst_data", DATA_OUT, 512'h0);
        RST = 1'b0;
        @(negedge clk);

        // Single fill, always ready, 1-cycle return
        ready_mode = 0; mem_lat = 1; key = '0;
        request(26'h3);
        wait_valid(lat);
        check("fill_latency", 32'(lat), 32'd18);
        check("word0", DATA_OUT[511:480], 32'hC0);
        check("word15", DATA_OUT[31:0], 32'hFC);
        check("block_single", DATA_OUT, model(26'h3, 32'h0));
        handshake();

        // Alternating ready, 3-cycle return, then a 5-cycle output stall
        ready_mode = 1; mem_lat = 3;
        fill(26'h3, 5);

        // Back-to-back: block 0 then the top block
        ready_mode = 0; mem_lat = 1;
        fill(26'h0, 0);
        fill(26'h3FFFFFF, 0);

        // Reset after 7 words have been returned
        request(26'h2A5A5);
        n = 0;
        while (rx_cnt < 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached", 1'(rx_cnt >= 7), 1'b1);
        RST       = 1'b1;
        flush_req = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        check("midrst_ain_ready", ADDRESS_IN_READY, 1'b1);
        check("midrst_rd_valid", MEM_READ_VALID, 1'b0);
        check("midrst_dov", DATA_OUT_VALID, 1'b0);
        check("midrst_data", DATA_OUT, 512'h0);
        @(negedge clk);
        key = 32'h5A5A_0F0F;
        fill(26'h2A5A5, 0);

        // Spurious data pulse in IDLE
        saved    = DATA_OUT;
        spur_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("spur_ain_ready", ADDRESS_IN_READY, 1'b1);
            check("spur_rd_valid", MEM_READ_VALID, 1'b0);
            check("spur_dov", DATA_OUT_VALID, 1'b0);
        end
        check("spur_data_held", DATA_OUT, saved);
        key = 32'h1234_5678;
        request(26'h1000);
        wait_valid(lat);
        check("spur_word0", DATA_OUT[511:480], 32'h0004_0000 ^ key);
        check("spur_block", DATA_OUT, model(26'h1000, key));
        handshake();

        // Randomized fills: random ready, latency, address, contents and output stall
        for (int t = 0; t < 6; t++) begin
            ready_mode = 2;
            mem_lat    = $urandom_range(1, 4);
            key        = $urandom;
            blk        = 26'($urandom);
            fill(blk, $urandom_range(0, 3));
        end

        check("queue_drained", 32'(pend_due.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instruction_block_fill_unit.md
Name: instruction_block_fill_unit

Overview:
- L2-side fill engine sitting directly downstream of the instruction cache miss interface.
- Accepts a 26-bit block address from the instruction cache and fetches the 16 words of that block over a 32-bit memory read bus.
- Assembles the words into one 512-bit block and returns it to the instruction cache over a valid/ready handshake.
- Supports multiple outstanding word reads; read data returns strictly in order.

Parameters:
- ADDRESS_WIDTH, 32, byte address width on memory bus
- WORD_SIZE, 4, bytes per word
- WORD_PER_BLOCK, 16, words per cache block (power of two)
- L2_BUS_WIDTH, 32, memory data bus width; equals WORD_SIZE*8
- BLOCK_ADDRESS_WIDTH, 26, ADDRESS_WIDTH - log2(WORD_PER_BLOCK*WORD_SIZE)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous active-high reset
- ADDRESS_IN_VALID  in  1  block request valid from instruction cache
- ADDRESS_IN_READY  out  1  block request accepted
- ADDRESS_IN  in  BLOCK_ADDRESS_WIDTH  requested block address
- MEM_READ_VALID  out  1  word read request valid
- MEM_READ_READY  in  1  memory accepts word read
- MEM_READ_ADDRESS  out  ADDRESS_WIDTH  byte address of word
- MEM_DATA_VALID  in  1  returned word valid (in request order; no backpressure)
- MEM_DATA  in  L2_BUS_WIDTH  returned word
- DATA_OUT_VALID  out  1  assembled block valid
- DATA_OUT_READY  in  1  instruction cache accepts block
- DATA_OUT  out  WORD_PER_BLOCK*L2_BUS_WIDTH  assembled block

Behaviour:
- Clock and reset: one clock (CLK); reset RST is synchronous and active-high.
- Reset values: state IDLE; ADDRESS_IN_READY=1; MEM_READ_VALID=0; DATA_OUT_VALID=0; MEM_READ_ADDRESS=0; DATA_OUT=0; both counters=0.
- FSM states: IDLE, FILL, RESP.
- IDLE:
  - ADDRESS_IN_READY=1.
  - On ADDRESS_IN_VALID, latch ADDRESS_IN, clear issue_cnt and recv_cnt, go to FILL next cycle.
  - Request-to-first-MEM_READ_VALID latency: 1 cycle.
- FILL:
  - ADDRESS_IN_READY=0.
  - MEM_READ_VALID=1 while issue_cnt<WORD_PER_BLOCK.
  - MEM_READ_ADDRESS = {block_addr, issue_cnt[3:0], 2'b00}.
  - issue_cnt increments on each MEM_READ_VALID & MEM_READ_READY.
  - MEM_READ_VALID and MEM_READ_ADDRESS stay stable until accepted.
  - Word 0 address = block_addr<<6; word 15 = (block_addr<<6)+60.
- Data capture:
  - Each MEM_DATA_VALID writes MEM_DATA into slot recv_cnt, then recv_cnt increments.
  - Word j occupies DATA_OUT[BLOCK_WIDTH-1-32*j -: 32], so word 0 is in the MSBs.
  - MEM_DATA_VALID in the same cycle as a read accept is legal; both are processed.
  - MEM_DATA_VALID in IDLE or RESP is ignored (protocol violation, no state change).
- FILL -> RESP: the cycle the 16th word is captured (recv_cnt reaches WORD_PER_BLOCK).
  - DATA_OUT_VALID=1 from the next cycle.
  - Minimum fill latency with memory always ready and 1-cycle data return: 18 cycles from request accept to DATA_OUT_VALID.
- RESP:
  - DATA_OUT_VALID and DATA_OUT hold stable until DATA_OUT_READY.
  - On the handshake, go to IDLE; ADDRESS_IN_READY=1 next cycle.
  - No new request is accepted in the same cycle as the output handshake.
- Counters are log2(WORD_PER_BLOCK)+1 bits wide and saturate at WORD_PER_BLOCK; no wrap.
- Reset mid-FILL or mid-RESP:
  - Returns to IDLE and drops the block.
  - The memory side is reset in the same cycle, so there are no stale returns.
- Only one block in flight; no abort input.

Test Plan:
- Single fill: memory word at byte addr A holds A; request ADDRESS_IN=26'h3, memory always ready with 1-cycle return.
  -> MEM_READ_ADDRESS sequence 0xC0..0xFC; DATA_OUT_VALID at cycle 18; DATA_OUT[511:480]=0xC0, DATA_OUT[31:0]=0xFC.
- MEM_READ_READY low on alternating cycles, data latency 3 cycles.
  -> addresses never skipped or repeated; each address held until accepted; block identical to the single-fill case.
- DATA_OUT_READY held low 5 cycles after DATA_OUT_VALID.
  -> DATA_OUT_VALID and DATA_OUT stable; ADDRESS_IN_READY=0; ADDRESS_IN_VALID pulsed during the stall is not accepted.
- Back-to-back requests for block 0 then block 26'h3FFFFFF.
  -> second fill addresses 0xFFFFFFC0..0xFFFFFFFC with no wrap; first block returned intact before the second is accepted.
- RST asserted after 7 words received.
  -> next cycle: IDLE, ADDRESS_IN_READY=1, MEM_READ_VALID=0, DATA_OUT_VALID=0; a subsequent fill completes correctly.
- Spurious MEM_DATA_VALID pulse in IDLE.
  -> no state change; the next fill's word 0 is correct.
